// File: rtl/if_ctrl.sv
// rtl/if_ctrl.sv - instruction fetch controller with prioritised redirect handling
// Holds one fetched word for decode and steers the PC on branch/debug/exception.
module if_ctrl #(
  parameter logic [31:0] FLUSH_INST = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        exception_req,
  input  logic [31:0] exception_target,
  input  logic        debug_req,
  input  logic [31:0] debug_target,
  input  logic        branch_req,
  input  logic [31:0] branch_target,
  output logic        pc_enable,
  output logic        do_exception,
  output logic        do_debug,
  output logic        do_branch,
  output logic [31:0] exception_addr,
  output logic [31:0] debug_addr,
  output logic [31:0] branch_addr,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_REDIR} state_t;
  // Encoding order doubles as priority so kinds compare numerically.
  typedef enum logic [1:0] {K_NONE, K_BRANCH, K_DEBUG, K_EXC} kind_t;

  state_t      state, state_nx;
  kind_t       pend_kind, pend_kind_nx, new_kind, upd_kind;
  logic [31:0] pend_target, pend_target_nx, new_target, upd_target;
  logic        inst_valid_nx;
  logic [31:0] inst_nx, inst_pc_nx;

  always_comb begin
    new_kind   = K_NONE;
    new_target = 32'h0;
    if (exception_req) begin
      new_kind   = K_EXC;
      new_target = exception_target;
    end else if (debug_req) begin
      new_kind   = K_DEBUG;
      new_target = debug_target;
    end else if (branch_req) begin
      new_kind   = K_BRANCH;
      new_target = branch_target;
    end
    upd_kind   = pend_kind;
    upd_target = pend_target;
    if (new_kind != K_NONE && new_kind >= pend_kind) begin
      upd_kind   = new_kind;
      upd_target = new_target;
    end
  end

  always_comb begin
    state_nx       = state;
    pend_kind_nx   = pend_kind;
    pend_target_nx = pend_target;
    inst_valid_nx  = inst_valid & id_stall;
    inst_nx        = inst;
    inst_pc_nx     = inst_pc;
    imem_req       = 1'b0;
    imem_addr      = 32'h0;
    pc_enable      = 1'b0;
    do_exception   = 1'b0;
    do_debug       = 1'b0;
    do_branch      = 1'b0;
    exception_addr = 32'h0;
    debug_addr     = 32'h0;
    branch_addr    = 32'h0;
    // Outputs stay quiet for the whole reset assertion, not just at the edge.
    if (rst_n) begin
      case (state)
        S_REQ: begin
          imem_req       = 1'b1;
          imem_addr      = pc_addr;
          pend_kind_nx   = upd_kind;
          pend_target_nx = upd_target;
          if (imem_ack) begin
            if (pend_kind != K_NONE || new_kind != K_NONE) begin
              inst_valid_nx = 1'b0;
              inst_nx       = FLUSH_INST;
              state_nx      = S_REDIR;
            end else begin
              inst_valid_nx = 1'b1;
              inst_nx       = imem_rdata;
              inst_pc_nx    = pc_addr;
              pc_enable     = 1'b1;
              state_nx      = id_stall ? S_WAIT : S_REQ;
            end
          end
        end
        S_WAIT: begin
          if (new_kind != K_NONE) begin
            pend_kind_nx   = upd_kind;
            pend_target_nx = upd_target;
            inst_valid_nx  = 1'b0;
            inst_nx        = FLUSH_INST;
            state_nx       = S_REDIR;
          end else if (!id_stall) begin
            state_nx = S_REQ;
          end
        end
        S_REDIR: begin
          case (pend_kind)
            K_EXC: begin
              do_exception   = 1'b1;
              exception_addr = pend_target;
            end
            K_DEBUG: begin
              do_debug   = 1'b1;
              debug_addr = pend_target;
            end
            K_BRANCH: begin
              do_branch   = 1'b1;
              branch_addr = pend_target;
              pc_enable   = 1'b1;
            end
            default: ;
          endcase
          if (new_kind != K_NONE) begin
            pend_kind_nx   = upd_kind;
            pend_target_nx = upd_target;
            inst_valid_nx  = 1'b0;
            inst_nx        = FLUSH_INST;
          end else begin
            pend_kind_nx   = K_NONE;
            pend_target_nx = 32'h0;
            state_nx       = S_REQ;
          end
        end
        default: state_nx = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pend_kind   <= K_NONE;
      pend_target <= 32'h0;
      inst_valid  <= 1'b0;
      inst        <= FLUSH_INST;
      inst_pc     <= 32'h0;
    end else begin
      state       <= state_nx;
      pend_kind   <= pend_kind_nx;
      pend_target <= pend_target_nx;
      inst_valid  <= inst_valid_nx;
      inst        <= inst_nx;
      inst_pc     <= inst_pc_nx;
    end
  end

endmodule

// File: tb/tb_if_ctrl.sv
// tb/tb_if_ctrl.sv - directed scoreboard bench for if_ctrl
module tb_if_ctrl;

  localparam logic [31:0] FLUSH = 32'h00000013;

  logic        clk, rst_n;
  logic [31:0] pc_addr, imem_addr, imem_rdata;
  logic        imem_req, imem_ack, id_stall;
  logic        exception_req, debug_req, branch_req;
  logic [31:0] exception_target, debug_target, branch_target;
  logic        pc_enable, do_exception, do_debug, do_branch;
  logic [31:0] exception_addr, debug_addr, branch_addr;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;

  if_ctrl #(.FLUSH_INST(FLUSH)) dut (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .id_stall(id_stall),
    .exception_req(exception_req), .exception_target(exception_target),
    .debug_req(debug_req), .debug_target(debug_target),
    .branch_req(branch_req), .branch_target(branch_target),
    .pc_enable(pc_enable), .do_exception(do_exception), .do_debug(do_debug),
    .do_branch(do_branch), .exception_addr(exception_addr),
    .debug_addr(debug_addr), .branch_addr(branch_addr),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
  );

  typedef struct { logic [31:0] word; logic [31:0] pc; } cap_t;
  typedef struct { logic [2:0] kind; logic [31:0] addr; } redir_t;
  cap_t   cap_q[$];
  redir_t redir_q[$];
  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_cap();
    cap_t e;
    if (cap_q.size() == 0) begin
      n_vec++; n_err++;
      $error("FAIL cap_q: observed empty expected entry");
    end else begin
      e = cap_q.pop_front();
      chk("inst_valid", 32'(inst_valid), 32'd1);
      chk("inst", inst, e.word);
      chk("inst_pc", inst_pc, e.pc);
    end
  endtask

  task automatic pop_redir();
    redir_t e;
    logic [31:0] addr;
    if (redir_q.size() == 0) begin
      n_vec++; n_err++;
      $error("FAIL redir_q: observed empty expected entry");
    end else begin
      e = redir_q.pop_front();
      chk("do_vec", 32'({do_exception, do_debug, do_branch}), 32'(e.kind));
      addr = e.kind[2] ? exception_addr : (e.kind[1] ? debug_addr : branch_addr);
      chk("redir_addr", addr, e.addr);
      chk("redir_pc_en", 32'(pc_enable), 32'(e.kind[0]));
      chk("redir_imem_req", 32'(imem_req), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; pc_addr = 32'hbfc00000; imem_ack = 1'b1; imem_rdata = 32'h11111111;
    id_stall = 1'b0; exception_req = 1'b0; debug_req = 1'b0; branch_req = 1'b0;
    exception_target = 32'h0; debug_target = 32'h0; branch_target = 32'h0;

    // reset state, with a stray ack present
    @(negedge clk);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, FLUSH);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_pc_enable", 32'(pc_enable), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_do_vec", 32'({do_exception, do_debug, do_branch}), 32'd0);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    post();

    // fetch with ack after two cycles
    repeat (2) begin
      @(negedge clk);
      chk("wait_imem_req", 32'(imem_req), 32'd1);
      chk("wait_imem_addr", imem_addr, 32'hbfc00000);
      chk("wait_pc_enable", 32'(pc_enable), 32'd0);
      post();
    end
    imem_ack = 1'b1; imem_rdata = 32'h24010001;
    cap_q.push_back('{32'h24010001, 32'hbfc00000});
    @(negedge clk);
    chk("cap_pc_enable", 32'(pc_enable), 32'd1);
    post();
    imem_ack = 1'b0; pc_addr = 32'hbfc00004;
    pop_cap();
    @(negedge clk);
    chk("single_pc_pulse", 32'(pc_enable), 32'd0);
    post();
    chk("consumed", 32'(inst_valid), 32'd0);

    // capture under stall, hold in S_WAIT
    imem_ack = 1'b1; imem_rdata = 32'h8c220004; id_stall = 1'b1;
    cap_q.push_back('{32'h8c220004, 32'hbfc00004});
    @(negedge clk);
    chk("stall_cap_pc_enable", 32'(pc_enable), 32'd1);
    post();
    imem_ack = 1'b0; pc_addr = 32'hbfc00008;
    pop_cap();
    repeat (3) begin
      @(negedge clk);
      chk("swait_imem_req", 32'(imem_req), 32'd0);
      chk("swait_imem_addr", imem_addr, 32'h0);
      post();
      chk("swait_inst", inst, 32'h8c220004);
      chk("swait_valid", 32'(inst_valid), 32'd1);
    end
    id_stall = 1'b0;
    @(negedge clk);
    chk("release_imem_req", 32'(imem_req), 32'd0);
    post();
    chk("release_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    chk("next_imem_req", 32'(imem_req), 32'd1);
    chk("next_imem_addr", imem_addr, 32'hbfc00008);
    post();

    // branch while fetch outstanding
    branch_req = 1'b1; branch_target = 32'h80000100;
    @(negedge clk);
    chk("br_pending_do", 32'(do_branch), 32'd0);
    chk("br_pending_req", 32'(imem_req), 32'd1);
    post();
    branch_req = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hdeadbeef;
    redir_q.push_back('{3'b001, 32'h80000100});
    @(negedge clk);
    chk("br_discard_pc_en", 32'(pc_enable), 32'd0);
    post();
    imem_ack = 1'b0;
    chk("br_flush_valid", 32'(inst_valid), 32'd0);
    chk("br_flush_inst", inst, FLUSH);
    @(negedge clk);
    pop_redir();
    post();
    pc_addr = 32'h80000100;
    @(negedge clk);
    chk("br_done_do", 32'({do_exception, do_debug, do_branch}), 32'd0);
    chk("br_new_addr", imem_addr, 32'h80000100);

    // branch and exception in the same cycle
    imem_ack = 1'b1; imem_rdata = 32'hffffffff;
    branch_req = 1'b1; branch_target = 32'h80000200;
    exception_req = 1'b1; exception_target = 32'h80000180;
    redir_q.push_back('{3'b100, 32'h80000180});
    post();
    imem_ack = 1'b0; branch_req = 1'b0; exception_req = 1'b0;
    chk("exc_flush_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    pop_redir();
    post();
    pc_addr = 32'h80000180;

    // pending exception is not displaced by a later debug request
    exception_req = 1'b1; exception_target = 32'h80000180;
    post();
    exception_req = 1'b0; debug_req = 1'b1; debug_target = 32'h80000800;
    post();
    debug_req = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h01234567;
    redir_q.push_back('{3'b100, 32'h80000180});
    post();
    imem_ack = 1'b0;
    @(negedge clk);
    pop_redir();
    post();

    // debug request while stalled in S_WAIT
    imem_ack = 1'b1; imem_rdata = 32'h12345678; id_stall = 1'b1;
    cap_q.push_back('{32'h12345678, 32'h80000180});
    post();
    imem_ack = 1'b0; pc_addr = 32'h80000184;
    pop_cap();
    debug_req = 1'b1; debug_target = 32'h80000800;
    redir_q.push_back('{3'b010, 32'h80000800});
    post();
    debug_req = 1'b0;
    chk("dbg_flush_valid", 32'(inst_valid), 32'd0);
    chk("dbg_flush_inst", inst, FLUSH);
    @(negedge clk);
    pop_redir();
    id_stall = 1'b0;
    post();
    pc_addr = 32'h80000800;

    // equal-priority overwrite, then reset pulse during S_REDIR
    branch_req = 1'b1; branch_target = 32'h80000300;
    post();
    branch_target = 32'h80000400; imem_ack = 1'b1;
    redir_q.push_back('{3'b001, 32'h80000400});
    post();
    branch_req = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    pop_redir();
    #1 rst_n = 1'b0;
    #1;
    chk("rstredir_do_vec", 32'({do_exception, do_debug, do_branch}), 32'd0);
    chk("rstredir_br_addr", branch_addr, 32'h0);
    chk("rstredir_pc_en", 32'(pc_enable), 32'd0);
    chk("rstredir_imem_req", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    post();
    @(negedge clk);
    chk("post_rst_imem_req", 32'(imem_req), 32'd1);
    chk("post_rst_imem_addr", imem_addr, 32'h80000800);
    chk("post_rst_do_vec", 32'({do_exception, do_debug, do_branch}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_ctrl.md
IF_CTRL -- requirements
Module: if_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_INST, default 32'h00000000: value loaded into inst on reset and on flush.
REQ-002 SHALL have port clk, input, 1: clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port pc_addr, input, 32: current PC from the program counter.
REQ-005 SHALL have ports imem_req (output, 1), imem_addr (output, 32) and imem_ack (input, 1): instruction bus handshake.
REQ-006 SHALL have port imem_rdata, input, 32: fetched word, valid when imem_ack=1.
REQ-007 SHALL have port id_stall, input, 1: decode cannot accept an instruction this cycle.
REQ-008 SHALL have input pairs exception_req/exception_target, debug_req/debug_target and branch_req/branch_target (1/32 each): redirect requests.
REQ-009 SHALL have outputs pc_enable, do_exception, do_debug and do_branch (1 each), plus exception_addr, debug_addr and branch_addr (32 each): PC control.
REQ-010 SHALL have outputs inst_valid (1), inst (32) and inst_pc (32): output buffer to decode.

Function
REQ-011 SHALL implement states S_REQ (fetch outstanding), S_WAIT (buffer full, decode stalled) and S_REDIR (apply redirect).
REQ-012 SHALL hold a pending-redirect register: kind (none, branch, debug or exception) plus a 32-bit target.
REQ-013 SHALL give redirect priority exception > debug > branch; among requests raised in the same cycle, only the highest is captured.
REQ-014 SHALL overwrite a pending redirect only with a new request of equal or higher priority; lower-priority requests SHALL be dropped.
REQ-015 SHALL drive imem_req=1 and imem_addr=pc_addr in S_REQ only; both SHALL be 0 elsewhere.
REQ-016 SHALL, in S_REQ with imem_ack=1, no redirect pending and none arriving, load inst=imem_rdata and inst_pc=pc_addr, set inst_valid=1 and drive pc_enable=1 for that cycle (PC +4).
REQ-017 SHALL, after a REQ-016 capture, go to S_WAIT if id_stall=1, else stay in S_REQ.
REQ-018 SHALL treat the buffer as consumed in any cycle where inst_valid=1 and id_stall=0; inst_valid SHALL then clear unless a new word is captured in the same cycle.
REQ-019 SHALL, in S_REQ with imem_ack=0, keep imem_req asserted and capture any redirect request into the pending register.
REQ-020 SHALL never abandon an outstanding fetch: in S_REQ with imem_ack=1 and a redirect pending or arriving, it SHALL discard imem_rdata, update pending, and go to S_REDIR.
REQ-021 SHALL, in S_WAIT, go to S_REQ when id_stall=0, and go to S_REDIR with the request captured when a redirect arrives.
REQ-022 SHALL, in S_REDIR, assert exactly one of do_exception, do_debug or do_branch per the pending kind, with the matching address output equal to the pending target.
REQ-023 SHALL assert pc_enable=1 in S_REDIR only for kind branch.
REQ-024 SHALL, in S_REDIR with no new request, clear pending and go to S_REQ; with a new request, update pending per REQ-014 and stay in S_REDIR.
REQ-025 SHALL flush on any redirect capture (entry to, or stay in, S_REDIR): inst_valid=0 and inst=FLUSH_INST; branch delay-slot handling is upstream's responsibility.
REQ-026 SHALL hold do_* at 0 and pc_enable at 0 in all cases not stated above.
REQ-027 SHALL keep inst and inst_pc unchanged while inst_valid=1 and id_stall=1.

Reset
REQ-028 SHALL, on rst_n=0, immediately set state=S_REQ, pending=none, inst_valid=0, inst=FLUSH_INST and inst_pc=0.
REQ-029 SHALL, while in reset, drive pc_enable=0, all do_*=0 and all *_addr outputs=0.
REQ-030 SHALL, in the first cycle after reset release, drive imem_req=1 with imem_addr=pc_addr.
REQ-031 SHALL, on reset asserted mid-fetch, drop the outstanding transaction; a late imem_ack SHALL be ignored.

Verification
REQ-032 SHALL cover: pc=32'hbfc00000, ack after 2 cycles, rdata=32'h24010001 -> inst_valid=1, inst_pc=32'hbfc00000, one pc_enable pulse.
REQ-033 SHALL cover: id_stall=1 for 3 cycles after capture -> state S_WAIT, imem_req=0, inst stable; then id_stall=0 -> next fetch at pc+4.
REQ-034 SHALL cover: branch_req with target 32'h80000100 while fetch outstanding -> fetch completes, rdata discarded, one-cycle do_branch with branch_addr=32'h80000100 and pc_enable=1, then fetch at the new PC.
REQ-035 SHALL cover: branch_req and exception_req (target 32'h80000180) in the same cycle -> only do_exception asserted, exception_addr=32'h80000180, inst_valid=0.
REQ-036 SHALL cover: exception pending, then debug_req before ack -> exception retained; debug_req dropped.
REQ-037 SHALL cover: rst_n pulsed low during S_REDIR -> all do_* drop immediately, pending cleared, imem_req=1 after release.
